eth_frame_scheduler: RTL and testbench
======================================

Name: eth_frame_scheduler

Overview:
Owns the packet-buffer BRAM write port and sequences the RAM-to-UART dump engine. Incoming Ethernet bytes are placed into a ring of fixed-size frame slots, and each completed frame's length is recorded. Committed frames are handed to the dump engine one at a time, in arrival order, as (read_start, read_end) ranges. Sits between dibits_to_bytes, bram_driver and ram_to_uart.

Parameters:
RAM_SIZE, 4096, packet buffer depth in bytes; power of 2.
SLOT_COUNT, 2, number of frame slots; power of 2, at least 2.
SLOT_SIZE, RAM_SIZE/SLOT_COUNT, bytes per slot (derived; not overridden).
AW, clog2(RAM_SIZE), RAM address width.

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  reset; synchronous, active-high.
in_val  in  8  received byte.
in_valid  in  1  one-cycle strobe; in_val is valid.
in_done  in  1  one-cycle end-of-frame pulse.
dump_enable  in  1  allows new dumps to be issued.
dump_done  in  1  one-cycle pulse; dump engine has finished the current range.
ram_write_enable  out  1  BRAM write strobe.
ram_write_addr  out  AW  BRAM write address.
ram_write_val  out  8  BRAM write data.
dump_start  out  1  one-cycle pulse that starts the dump engine.
dump_read_start  out  AW  first byte address of the frame.
dump_read_end  out  AW  one past the last byte, modulo 2^AW.
dump_busy  out  1  high from dump_start until dump_done.
frames_pending  out  clog2(SLOT_COUNT)+1  number of committed, undumped slots.
drop_count  out  16  frames dropped; saturates at 16'hFFFF.

Behaviour:
- Reset values: all outputs 0. wr_slot=0, rd_slot=0, all slot valid bits clear, write state W_IDLE, read state R_IDLE.
- Write FSM, W_IDLE:
  - in_valid with slot wr_slot free (valid bit clear) -> write byte at offset 0, offset=1, go W_RECV.
  - in_valid with no free slot -> go W_DROP; byte discarded.
- W_RECV:
  - Each in_valid writes the byte to wr_slot*SLOT_SIZE+offset, then offset++.
  - ram_write_enable is registered, so the write appears 1 cycle after in_valid; address and data are aligned with the enable.
- W_RECV, in_valid while offset==SLOT_SIZE -> overflow: no write, go W_DROP.
- W_DROP: ignore all bytes. On in_done: drop_count++ (saturating), go W_IDLE.
- W_RECV, in_done -> commit:
  - len[wr_slot]=offset; valid[wr_slot]=1; wr_slot=(wr_slot+1) mod SLOT_COUNT; go W_IDLE.
  - in_valid and in_done in the same cycle: the byte is written first, then the frame commits including that byte.
- W_IDLE, in_done -> ignored; no commit, no drop.
- Read FSM, R_IDLE: if dump_enable and valid[rd_slot]:
  - Latch dump_read_start=rd_slot*SLOT_SIZE and dump_read_end=(dump_read_start+len) mod 2^AW.
  - dump_start=1 for exactly 1 cycle; dump_busy=1; go R_WAIT.
- R_WAIT: range outputs held stable.
  - On dump_done: valid[rd_slot]=0; rd_slot advances; dump_busy=0; go R_IDLE.
  - No new dump_start in the same cycle, so there is at least 1 idle cycle between dumps.
- R_IDLE, dump_done -> ignored.
- Slot being dumped stays valid, so it is never overwritten mid-dump.
- Simultaneous commit and release in the same cycle: both take effect. frames_pending is unchanged by that cycle's net effect.
- Deasserting dump_enable in R_WAIT does not abort the current dump; it only blocks the next one.
- Full slot (len==SLOT_SIZE) in the last slot: dump_read_end wraps to 0. This is intended; the dump engine compares wrapped addresses.
- Reset mid-frame or mid-dump:
  - Immediate return to reset state; all slots invalidated.
  - In-flight dump_done after reset is ignored.

Test Plan:
- Single frame: send 60 bytes 0x00..0x3B then in_done, dump_enable=1. Required: writes to addresses 0..59 with matching data; dump_start one cycle with start=0, end=60; frames_pending 1 -> 0 after dump_done.
- Back-to-back frames: 10 bytes then 20 bytes. Required: second frame written at 2048..2067; dumps issued in order (0,10) then (2048,2068); second dump_start occurs only after the first dump_done.
- Buffer full with SLOT_COUNT=2, dump_enable=0: send 3 frames. Required: first two committed (frames_pending=2); third produces no writes; drop_count=1.
- Overflow: send a 2049-byte frame. Required: 2048 writes then none; frame not committed; drop_count=1. A full 2048-byte frame in slot 1 dumps with end=0.
- Same-cycle events: in_done for a frame coincides with dump_done for another. Required: frames_pending unchanged; both slot states updated correctly. A lone in_done while in W_IDLE: no effect.
- Reset mid-dump: assert reset while in R_WAIT. Required: dump_busy=0 and frames_pending=0 next cycle; a later dump_done produces no dump_start.

Source files
------------

// File: rtl/eth_frame_scheduler.sv
// eth_frame_scheduler: packs received frames into ring slots in BRAM and hands them to the dump engine in arrival order
module eth_frame_scheduler #(
  parameter int RAM_SIZE = 4096,
  parameter int SLOT_COUNT = 2,
  parameter int AW = $clog2(RAM_SIZE)
) (
  input logic clk,
  input logic reset,
  input logic [7:0] in_val,
  input logic in_valid,
  input logic in_done,
  input logic dump_enable,
  input logic dump_done,
  output logic ram_write_enable,
  output logic [AW-1:0] ram_write_addr,
  output logic [7:0] ram_write_val,
  output logic dump_start,
  output logic [AW-1:0] dump_read_start,
  output logic [AW-1:0] dump_read_end,
  output logic dump_busy,
  output logic [$clog2(SLOT_COUNT):0] frames_pending,
  output logic [15:0] drop_count
);
  localparam int SLOT_SIZE = RAM_SIZE / SLOT_COUNT;
  localparam int SW = $clog2(SLOT_COUNT);
  localparam int LW = AW - SW;
  localparam int OW = LW + 1;
  localparam int PW = SW + 1;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_RECV = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_WAIT = 1'b1;
  logic [1:0] w_state;
  logic [0:0] r_state;
  logic [SW-1:0] wr_slot;
  logic [SW-1:0] rd_slot;
  logic [SLOT_COUNT-1:0] valid;
  logic [OW-1:0] len [SLOT_COUNT];
  logic [OW-1:0] offset;
  logic [OW-1:0] wr_off;
  logic [OW-1:0] next_off;
  logic slot_free;
  logic room;
  logic start_frame;
  logic overflow;
  logic take;
  logic commit;
  logic drop_begin;
  logic drop_end;
  logic issue;
  logic finish_dump;
  // Decode this cycle's write/read events; a byte arriving with in_done is written before the commit
  always_comb begin
    slot_free = !valid[wr_slot];
    room = offset != OW'(SLOT_SIZE);
    start_frame = w_state == W_IDLE && in_valid && slot_free;
    overflow = w_state == W_RECV && in_valid && !room;
    take = start_frame || (w_state == W_RECV && in_valid && room);
    commit = in_done && (start_frame || (w_state == W_RECV && !overflow));
    drop_begin = in_valid && ((w_state == W_IDLE && !slot_free) || overflow);
    drop_end = in_done && (w_state == W_DROP || drop_begin);
    wr_off = start_frame ? '0 : offset;
    next_off = wr_off + OW'(take);
    issue = r_state == R_IDLE && dump_enable && valid[rd_slot];
    finish_dump = r_state == R_WAIT && dump_done;
    dump_busy = r_state == R_WAIT;
  end
  // Write side: place bytes into the current slot, drop frames with no room, count drops
  always_ff @(posedge clk)
    if (reset) begin
      w_state <= W_IDLE;
      offset <= '0;
      wr_slot <= '0;
      drop_count <= '0;
      ram_write_enable <= 1'b0;
      ram_write_addr <= '0;
      ram_write_val <= '0;
    end else begin
      w_state <= commit || drop_end ? W_IDLE : drop_begin ? W_DROP : start_frame ? W_RECV : w_state;
      offset <= next_off;
      wr_slot <= wr_slot + SW'(commit);
      drop_count <= drop_count + 16'(drop_end && drop_count != 16'hFFFF);
      ram_write_enable <= take;
      ram_write_addr <= {wr_slot, wr_off[LW-1:0]};
      ram_write_val <= in_val;
    end
  // Committed frame lengths; only meaningful while the slot is valid
  always_ff @(posedge clk)
    if (commit) len[wr_slot] <= next_off;
  // Slot occupancy: commit and release always target different slots, so both can apply at once
  always_ff @(posedge clk)
    if (reset) begin
      valid <= '0;
      frames_pending <= '0;
    end else begin
      valid <= (valid | (SLOT_COUNT'(commit) << wr_slot)) & ~(SLOT_COUNT'(finish_dump) << rd_slot);
      frames_pending <= frames_pending + PW'(commit) - PW'(finish_dump);
    end
  // Read side: issue one dump per committed slot and hold its range until the engine finishes
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= R_IDLE;
      rd_slot <= '0;
      dump_start <= 1'b0;
      dump_read_start <= '0;
      dump_read_end <= '0;
    end else begin
      r_state <= issue ? R_WAIT : finish_dump ? R_IDLE : r_state;
      rd_slot <= rd_slot + SW'(finish_dump);
      dump_start <= issue;
      if (issue) begin
        dump_read_start <= {rd_slot, {LW{1'b0}}};
        dump_read_end <= {rd_slot, {LW{1'b0}}} + AW'(len[rd_slot]);
      end
    end
endmodule

// File: tb/tb_eth_frame_scheduler.sv
// tb_eth_frame_scheduler: random and directed frames checked every cycle against a queue-based model
module tb_eth_frame_scheduler;
  localparam int RS = 4096;
  localparam int SC = 2;
  localparam int SS = RS / SC;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_val = '0;
  logic in_valid = 1'b0;
  logic in_done = 1'b0;
  logic dump_enable = 1'b0;
  logic dump_done = 1'b0;
  logic ram_write_enable;
  logic [11:0] ram_write_addr;
  logic [7:0] ram_write_val;
  logic dump_start;
  logic [11:0] dump_read_start;
  logic [11:0] dump_read_end;
  logic dump_busy;
  logic [1:0] frames_pending;
  logic [15:0] drop_count;
  eth_frame_scheduler #(.RAM_SIZE(RS), .SLOT_COUNT(SC)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_valid(in_valid), .in_done(in_done),
    .dump_enable(dump_enable), .dump_done(dump_done),
    .ram_write_enable(ram_write_enable), .ram_write_addr(ram_write_addr), .ram_write_val(ram_write_val),
    .dump_start(dump_start), .dump_read_start(dump_read_start), .dump_read_end(dump_read_end),
    .dump_busy(dump_busy), .frames_pending(frames_pending), .drop_count(drop_count)
  );
  always #10 clk = ~clk;
  int pend[$];
  bit m_armed = 0, m_rcv = 0, m_drp = 0, m_we = 0, m_start = 0, m_busy = 0, m_com = 0, m_rel = 0;
  int m_cnt = 0, m_len = 0, m_commits = 0, m_releases = 0, m_drops = 0;
  int m_addr = 0, m_data = 0, m_rs = 0, m_re = 0;
  int n_cmp = 0, n_err = 0, ack_cnt = 0;
  bit auto_ack = 0, force_dd = 0, rand_en = 0, gaps = 0;
  // Reference: frames as a FIFO of lengths; slot of the k-th frame is k mod SC
  always @(posedge clk) begin
    if (reset) begin
      m_armed = 1; pend.delete(); m_rcv = 0; m_drp = 0; m_cnt = 0; m_commits = 0; m_releases = 0;
      m_drops = 0; m_we = 0; m_start = 0; m_busy = 0; m_rs = 0; m_re = 0;
    end else begin
      m_we = 0; m_com = 0; m_rel = 0; m_start = 0;
      if (in_valid) begin
        if (!m_rcv && !m_drp) begin
          if (pend.size() < SC) begin m_rcv = 1; m_cnt = 0; end
          else m_drp = 1;
        end
        if (m_rcv) begin
          if (m_cnt == SS) begin m_rcv = 0; m_drp = 1; end
          else begin m_we = 1; m_addr = (m_commits % SC) * SS + m_cnt; m_data = in_val; m_cnt++; end
        end
      end
      if (in_done) begin
        if (m_rcv) begin m_com = 1; m_len = m_cnt; m_rcv = 0; end
        else if (m_drp) begin if (m_drops < 65535) m_drops++; m_drp = 0; end
      end
      if (m_busy) begin
        if (dump_done) begin m_busy = 0; m_rel = 1; end
      end else if (dump_enable && pend.size() > 0) begin
        m_rs = (m_releases % SC) * SS; m_re = (m_rs + pend[0]) % RS; m_start = 1; m_busy = 1;
      end
      if (m_rel) begin void'(pend.pop_front()); m_releases++; end
      if (m_com) begin pend.push_back(m_len); m_commits++; end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic dn);
    @(negedge clk);
    if (m_armed) begin
      chk("we", ram_write_enable, m_we);
      if (m_we) begin chk("waddr", ram_write_addr, m_addr); chk("wdata", ram_write_val, m_data); end
      chk("dump_start", dump_start, m_start);
      chk("dump_busy", dump_busy, m_busy);
      chk("read_start", dump_read_start, m_rs);
      chk("read_end", dump_read_end, m_re);
      chk("pending", frames_pending, pend.size());
      chk("drops", drop_count, m_drops);
    end
    in_valid = v; in_val = d; in_done = dn;
    dump_done = force_dd; force_dd = 0;
    if (ack_cnt > 0) begin ack_cnt--; if (ack_cnt == 0) dump_done = 1; end
    if (dump_start && auto_ack) ack_cnt = $urandom_range(1, 6);
    if (rand_en) dump_enable = $urandom_range(0, 3) != 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic send(input int n, input int base, input bit together);
    for (int i = 0; i < n; i++) begin
      step(1, 8'(base >= 0 ? base + i : $urandom_range(0, 255)), together && i == n - 1);
      if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) step(0, 0, 0);
    end
    if (!together) step(0, 0, 1);
  endtask
  task automatic do_reset();
    reset = 1; idle(2); reset = 0;
  endtask
  task automatic wait_start(input string name);
    bit seen = 0;
    for (int k = 0; k < 500 && !seen; k++) begin step(0, 0, 0); seen = dump_start; end
    chk({name, "_start_seen"}, seen, 1);
  endtask
  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 500 && !done; k++) begin step(0, 0, 0); done = !dump_busy; end
    chk({name, "_idle_seen"}, done, 1);
  endtask
  initial begin
    do_reset();
    idle(1);
    chk("rst_busy", dump_busy, 0); chk("rst_pend", frames_pending, 0); chk("rst_drops", drop_count, 0);
    chk("rst_we", ram_write_enable, 0); chk("rst_start", dump_start, 0); chk("rst_rend", dump_read_end, 0);
    dump_enable = 1; auto_ack = 1;
    send(60, 0, 0);
    wait_start("single");
    chk("single_rs", dump_read_start, 0); chk("single_re", dump_read_end, 60); chk("single_pend", frames_pending, 1);
    wait_idle("single");
    chk("single_pend0", frames_pending, 0);
    do_reset(); dump_enable = 0;
    send(10, -1, 0); send(20, -1, 0); idle(2);
    chk("b2b_pend", frames_pending, 2);
    dump_enable = 1;
    wait_start("b2b1"); chk("b2b1_rs", dump_read_start, 0); chk("b2b1_re", dump_read_end, 10);
    wait_idle("b2b1");
    wait_start("b2b2"); chk("b2b2_rs", dump_read_start, 2048); chk("b2b2_re", dump_read_end, 2068);
    wait_idle("b2b2");
    do_reset(); dump_enable = 0;
    send(5, -1, 0); send(7, -1, 0); send(9, -1, 0); idle(2);
    chk("full_pend", frames_pending, 2); chk("full_drops", drop_count, 1);
    dump_enable = 1; idle(60);
    chk("full_pend0", frames_pending, 0);
    do_reset(); dump_enable = 0;
    send(2049, -1, 0); idle(2);
    chk("ovf_drops", drop_count, 1); chk("ovf_pend", frames_pending, 0);
    send(1, -1, 0); send(2048, -1, 1); idle(2);
    chk("wrap_pend", frames_pending, 2);
    dump_enable = 1;
    wait_start("wrap1"); chk("wrap1_re", dump_read_end, 1);
    wait_idle("wrap1");
    wait_start("wrap2"); chk("wrap2_rs", dump_read_start, 2048); chk("wrap2_re", dump_read_end, 0);
    wait_idle("wrap2");
    do_reset(); dump_enable = 1; auto_ack = 0;
    send(4, -1, 0);
    wait_start("same");
    chk("same_pend_before", frames_pending, 1);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom_range(0, 255)), 0);
    force_dd = 1; step(0, 0, 1);
    dump_enable = 0;
    idle(1);
    chk("same_pend_after", frames_pending, 1); chk("same_busy", dump_busy, 0);
    step(0, 0, 1); idle(2);
    chk("lone_done_pend", frames_pending, 1); chk("lone_done_drops", drop_count, 0);
    dump_enable = 1;
    wait_start("same2"); chk("same2_rs", dump_read_start, 2048); chk("same2_re", dump_read_end, 2053);
    force_dd = 1; idle(2);
    chk("same2_pend", frames_pending, 0);
    do_reset(); dump_enable = 1;
    send(8, -1, 0);
    wait_start("rstdump"); idle(2);
    reset = 1; step(0, 0, 0); reset = 0;
    chk("rstdump_busy", dump_busy, 0); chk("rstdump_pend", frames_pending, 0);
    force_dd = 1; idle(5);
    chk("rstdump_busy_late", dump_busy, 0);
    auto_ack = 1; rand_en = 1; gaps = 1;
    do_reset();
    repeat (60) begin
      send($urandom_range(0, 19) == 0 ? $urandom_range(2040, 2050) : $urandom_range(1, 40), -1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) step(0, 0, 1);
      if ($urandom_range(0, 29) == 0) do_reset();
      idle($urandom_range(0, 5));
    end
    rand_en = 0; dump_enable = 1;
    idle(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
